fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer between the PC source and the instruction port of ifetch/if_id.

---
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_fetch_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-fetch bus bundle: memory req/gnt/rvalid port plus
// the valid/ready instruction stream towards if_id.
interface fetch_ctrl_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        instValidOut;
  logic [31:0] instAddrOut;
  logic [31:0] instOut;
  logic        instReadyIn;

  modport master (
    output memReq, memAddr,
    input  memGnt, memRvalid, memRdata,
    output instValidOut, instAddrOut, instOut,
    input  instReadyIn
  );

  modport slave (
    input  memReq, memAddr,
    output memGnt, memRvalid, memRdata,
    input  instValidOut, instAddrOut, instOut,
    output instReadyIn
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, credits requests against the output buffer,
// tags in-order responses and drops stale ones after a redirect. Option: FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jumpEn,
  input  logic [31:0] jumpAddr,
  output logic        fetchErrOut,
  fetch_ctrl_if.master bus
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc;
  logic [CW-1:0] outst, disc, count;
  logic [AW-1:0] tw, tr, ow, orp;
  logic [31:0]   tagq    [BUF_DEPTH];
  logic [31:0]   ob_addr [BUF_DEPTH];
  logic [31:0]   ob_data [BUF_DEPTH];
  logic [31:0]   last_addr, last_inst;
  logic          err_q, bad;
  logic [31:0]   tgt;
  logic          pop, push, accept, valid;
  logic [CW:0]   inflight;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bad = |jumpAddr[1:0];
  assign tgt = jumpAddr;

  always_ff @(posedge clk) begin
    if (!rst)        err_q <= 1'b0;
    else if (jumpEn) err_q <= bad;
  end
`else
  logic unused_lo;
  assign unused_lo = ^jumpAddr[1:0];
  assign bad   = 1'b0;
  assign tgt   = {jumpAddr[31:2], 2'b00};
  assign err_q = 1'b0;
`endif

  assign fetchErrOut = err_q;

  assign valid = count != '0;
  assign pop   = valid && bus.instReadyIn;
  assign push  = bus.memRvalid && disc == '0 && !jumpEn;

  // Credit covers every in-flight request, discarded ones included.
  assign inflight = {1'b0, outst} + {1'b0, count}
                  - {{CW{1'b0}}, pop};

  assign bus.memReq  = rst && !jumpEn && !err_q
                    && inflight < DEPTH_W;
  assign bus.memAddr = pc;
  assign accept      = bus.memReq && bus.memGnt;

  assign bus.instValidOut = valid;
  assign bus.instAddrOut  = valid ? ob_addr[orp] : last_addr;
  assign bus.instOut      = valid ? ob_data[orp] : last_inst;

  always_ff @(posedge clk) begin
    if (accept) tagq[tw] <= pc;
    if (push) begin
      ob_addr[ow] <= tagq[tr];
      ob_data[ow] <= bus.memRdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= RESET_PC;
      outst     <= '0;
      disc      <= '0;
      count     <= '0;
      tw        <= '0;
      tr        <= '0;
      ow        <= '0;
      orp       <= '0;
      last_addr <= '0;
      last_inst <= NOP;
    end else begin
      if (jumpEn && !bad) pc <= tgt;
      else if (accept)    pc <= pc + 32'd4;

      if (accept)        tw <= tw + AW'(1);
      if (bus.memRvalid) tr <= tr + AW'(1);

      unique case (1'b1)
        accept && !bus.memRvalid: outst <= outst + CW'(1);
        !accept && bus.memRvalid: outst <= outst - CW'(1);
        default: ;
      endcase

      // Everything still in flight after a redirect is stale.
      if (jumpEn)
        disc <= outst - CW'(bus.memRvalid);
      else if (bus.memRvalid && disc != '0)
        disc <= disc - CW'(1);

      if (jumpEn) begin
        orp   <= ow;
        count <= '0;
        if (valid) begin
          last_addr <= ob_addr[orp];
          last_inst <= ob_data[orp];
        end
      end else begin
        if (push) ow <= ow + AW'(1);
        if (pop) begin
          orp       <= orp + AW'(1);
          last_addr <= ob_addr[orp];
          last_inst <= ob_data[orp];
        end
        unique case (1'b1)
          push && !pop: count <= count + CW'(1);
          pop && !push: count <= count - CW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: cycle table plus memory model and
// in-order stream scoreboard for stalls, random gnt/latency and redirects.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jumpEn = 1'b0;
  logic [31:0] jumpAddr = '0;
  logic        fetchErrOut;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .jumpEn(jumpEn),
    .jumpAddr(jumpAddr),
    .fetchErrOut(fetchErrOut),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic        j;
    logic [31:0] ja;
    logic        rdy;
    logic        v;
    logic [31:0] a;
    logic        req;
    logic [31:0] ma;
  } vec_t;

  req_t        pend[$];
  vec_t        tbl[20];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, last_due = 0, pops = 0;
  int          lat_lo = 1, lat_hi = 1, lat_k;
  bit          gnt_rand = 0;
  bit          prev_hold = 0;
  logic        rst_v = 1'b0;
  logic [31:0] exp_next = '0, prev_addr = '0;

  initial begin
    bus.memGnt      = 1'b0;
    bus.memRvalid   = 1'b0;
    bus.memRdata    = '0;
    bus.instReadyIn = 1'b0;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic drive(input logic j, input logic [31:0] ja,
                       input logic rdy);
    @(negedge clk);
    rst = rst_v;
    jumpEn = j;
    jumpAddr = ja;
    bus.instReadyIn = rdy;
    bus.memGnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      bus.memRvalid = 1'b1;
      bus.memRdata  = ~pend[0].addr;
    end else begin
      bus.memRvalid = 1'b0;
      bus.memRdata  = 32'hdead_beef;
    end
    #1;
  endtask

  task automatic commit();
    int due;
    if (prev_hold && bus.memReq)
      check("addr_stable", bus.memAddr, prev_addr);
    prev_hold = bus.memReq && !bus.memGnt;
    prev_addr = bus.memAddr;
    if (rst && bus.instValidOut && bus.instReadyIn && !jumpEn) begin
      check("stream_addr", bus.instAddrOut, exp_next);
      check("stream_data", bus.instOut, ~exp_next);
      exp_next += 32'd4;
      pops++;
    end
    if (jumpEn) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (jumpAddr[1:0] == 2'b00) exp_next = jumpAddr;
`else
      exp_next = {jumpAddr[31:2], 2'b00};
`endif
    end
    if (bus.memRvalid) void'(pend.pop_front());
    if (bus.memReq && bus.memGnt) begin
      due = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{bus.memAddr, due});
    end
    cyc++;
  endtask

  task automatic tick(input logic j, input logic [31:0] ja,
                      input logic rdy);
    drive(j, ja, rdy);
    commit();
  endtask

  task automatic do_reset();
    rst_v = 1'b0;
    pend.delete();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      check("req_in_reset", 32'(bus.memReq), 32'h0);
      commit();
    end
    pend.delete();
    prev_hold = 0;
    last_due = cyc;
    exp_next = 32'h0;
    rst_v = 1'b1;
  endtask

  task automatic wait_first(input string nm, input logic [31:0] exp,
                            input int limit, output int lat);
    bit seen = 0;
    lat = -1;
    for (int k = 0; k < limit; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      if (bus.instValidOut) begin
        seen = 1;
        lat = k;
        check(nm, bus.instAddrOut, exp);
        commit();
        break;
      end
      commit();
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL %s: no instValidOut within %0d cycles", nm, limit);
    end
  endtask

  function automatic vec_t mk(logic j, logic [31:0] ja, logic rdy,
                              logic v, logic [31:0] a, logic req,
                              logic [31:0] ma);
    vec_t t;
    t = '{j, ja, rdy, v, a, req, ma};
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(0, 0, 1, 0, 32'h00, 1, 32'h00);
    tbl[1]  = mk(0, 0, 1, 0, 32'h00, 1, 32'h04);
    tbl[2]  = mk(0, 0, 1, 1, 32'h00, 1, 32'h08);
    tbl[3]  = mk(0, 0, 1, 1, 32'h04, 1, 32'h0C);
    tbl[4]  = mk(0, 0, 1, 1, 32'h08, 1, 32'h10);
    tbl[5]  = mk(0, 0, 1, 1, 32'h0C, 1, 32'h14);
    tbl[6]  = mk(0, 0, 0, 1, 32'h10, 0, 32'h18);
    tbl[7]  = mk(0, 0, 0, 1, 32'h10, 0, 32'h18);
    tbl[8]  = mk(0, 0, 0, 1, 32'h10, 0, 32'h18);
    tbl[9]  = mk(0, 0, 0, 1, 32'h10, 0, 32'h18);
    tbl[10] = mk(0, 0, 0, 1, 32'h10, 0, 32'h18);
    tbl[11] = mk(0, 0, 1, 1, 32'h10, 1, 32'h18);
    tbl[12] = mk(0, 0, 1, 1, 32'h14, 1, 32'h1C);
    tbl[13] = mk(0, 0, 1, 1, 32'h18, 1, 32'h20);
    tbl[14] = mk(0, 0, 1, 1, 32'h1C, 1, 32'h24);
    tbl[15] = mk(1, 32'h100, 1, 1, 32'h20, 0, 32'h28);
    tbl[16] = mk(0, 0, 1, 0, 32'h00, 1, 32'h100);
    tbl[17] = mk(0, 0, 1, 0, 32'h00, 1, 32'h104);
    tbl[18] = mk(0, 0, 1, 1, 32'h100, 1, 32'h108);
    tbl[19] = mk(0, 0, 1, 1, 32'h104, 1, 32'h10C);

    // gnt=1, 1-cycle rvalid: startup, stall, resume, redirect
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].j, tbl[i].ja, tbl[i].rdy);
      check($sformatf("v%0d_valid", i),
            32'(bus.instValidOut), 32'(tbl[i].v));
      if (tbl[i].v || i == 0)
        check($sformatf("v%0d_addr", i), bus.instAddrOut, tbl[i].a);
      check($sformatf("v%0d_req", i), 32'(bus.memReq), 32'(tbl[i].req));
      if (tbl[i].req)
        check($sformatf("v%0d_maddr", i), bus.memAddr, tbl[i].ma);
      if (i == 0) begin
        check("rst_inst", bus.instOut, 32'h0000_0013);
        check("rst_err", 32'(fetchErrOut), 32'h0);
      end
      commit();
    end

    // redirect with two responses in flight
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    for (int k = 0; k < 6; k++) tick(1'b0, 32'h0, 1'b1);
    check("inflight_before_jump", pend.size(), 32'd2);
    tick(1'b1, 32'h100, 1'b1);
    wait_first("jump_first", 32'h100, 20, lat_k);
    for (int k = 0; k < 10; k++) tick(1'b0, 32'h0, 1'b1);

    // jump on an rvalid+pop cycle, then again to 0x200
    do_reset();
    lat_lo = 1;
    lat_hi = 1;
    for (int k = 0; k < 8; k++) tick(1'b0, 32'h0, 1'b1);
    tick(1'b1, 32'h100, 1'b1);
    tick(1'b1, 32'h200, 1'b1);
    wait_first("jump2_first", 32'h200, 20, lat_k);
    check("jump2_latency", lat_k, 32'd2);
    for (int k = 0; k < 10; k++) tick(1'b0, 32'h0, 1'b1);

    // misaligned redirect
    do_reset();
    for (int k = 0; k < 4; k++) tick(1'b0, 32'h0, 1'b1);
    tick(1'b1, 32'h102, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_err", 32'(fetchErrOut), 32'h1);
    check("mis_req", 32'(bus.memReq), 32'h0);
    commit();
    for (int k = 0; k < 3; k++) tick(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("mis_req_held", 32'(bus.memReq), 32'h0);
    commit();
    tick(1'b1, 32'h104, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("mis_clr_err", 32'(fetchErrOut), 32'h0);
    check("mis_clr_req", 32'(bus.memReq), 32'h1);
    check("mis_clr_maddr", bus.memAddr, 32'h104);
    commit();
    wait_first("mis_first", 32'h104, 20, lat_k);
`else
    check("mis_err", 32'(fetchErrOut), 32'h0);
    check("mis_req", 32'(bus.memReq), 32'h1);
    check("mis_maddr", bus.memAddr, 32'h100);
    commit();
    wait_first("mis_first", 32'h100, 20, lat_k);
`endif
    for (int k = 0; k < 6; k++) tick(1'b0, 32'h0, 1'b1);

    // random gnt, latency 1..4, random ready and occasional jumps
    do_reset();
    gnt_rand = 1;
    lat_lo = 1;
    lat_hi = 4;
    pops = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 29) == 0)
        tick(1'b1, {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, 1'b1);
      else
        tick(1'b0, 32'h0, 1'($urandom_range(0, 9) < 7));
    end
    check("random_progress", 32'(pops > 40), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
